// File: rtl/integral_image_feeder.sv
// integral_image_feeder: builds a WIDTH x WIDTH integral image from a
// raster pixel stream and hands the finished frame to the classifier.
module integral_image_feeder #(
    parameter int WIDTH      = 20,
    parameter int BITSIZE    = 9,
    parameter int PIXEL_BITS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PIXEL_BITS-1:0]            pixel_in,
    input  logic                             pixel_valid,
    output logic                             pixel_ready,
    input  logic                             request_new_data,
    output logic [WIDTH*WIDTH*BITSIZE-1:0]   image,
    output logic                             en,
    output logic                             saturated
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int NE = WIDTH * WIDTH;
    localparam int OW = $clog2(NE * BITSIZE) + 1;
    localparam logic [BITSIZE-1:0] MAXV = '1;

    typedef enum logic {FILL, READY} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]      x_q;
    logic [CW-1:0]      y_q;
    logic [BITSIZE-1:0] row_sum;
    logic               sat_q;

    logic               accept;
    logic               x_last;
    logic               y_last;
    logic [BITSIZE-1:0] base;
    logic [BITSIZE-1:0] above;
    logic [BITSIZE:0]   rs_full;
    logic [BITSIZE:0]   elem_full;
    logic [BITSIZE-1:0] rs_new;
    logic [BITSIZE-1:0] elem_new;
    logic               rs_clip;
    logic               elem_clip;
    logic [OW-1:0]      wr_off;
    logic [OW-1:0]      rd_off;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    // Next-state: last pixel ends the fill, a request restarts it
    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:  if (accept && x_last && y_last) state_nxt = READY;
            READY: if (request_new_data) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        pixel_ready = (state == FILL) && !rst;
        en          = (state == READY);
        saturated   = sat_q;
    end

    // Accumulation datapath: row prefix, then add element above, clipping both
    always_comb begin
        accept    = pixel_valid && pixel_ready;
        x_last    = (x_q == CW'(WIDTH - 1));
        y_last    = (y_q == CW'(WIDTH - 1));
        wr_off    = (OW'(y_q) * OW'(WIDTH) + OW'(x_q)) * OW'(BITSIZE);
        rd_off    = wr_off - OW'(WIDTH * BITSIZE);
        base      = (x_q == '0) ? '0 : row_sum;
        above     = (y_q == '0) ? '0 : image[rd_off +: BITSIZE];
        rs_full   = (BITSIZE+1)'(base) + (BITSIZE+1)'(pixel_in);
        rs_clip   = rs_full[BITSIZE];
        rs_new    = rs_clip ? MAXV : rs_full[BITSIZE-1:0];
        elem_full = (BITSIZE+1)'(above) + (BITSIZE+1)'(rs_new);
        elem_clip = elem_full[BITSIZE];
        elem_new  = elem_clip ? MAXV : elem_full[BITSIZE-1:0];
    end

    // Counters, row sum, image storage and sticky clip flag
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            row_sum <= '0;
            image   <= '0;
            sat_q   <= 1'b0;
        end else if (accept) begin
            image[wr_off +: BITSIZE] <= elem_new;
            row_sum <= rs_new;
            if (rs_clip || elem_clip) sat_q <= 1'b1;
            if (x_last) begin
                x_q <= '0;
                y_q <= y_last ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end else if (state == READY && request_new_data) begin
            sat_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_integral_image_feeder.sv
// Bench for integral_image_feeder: table of frame patterns plus
// hand sequences for turnaround and mid-frame reset.
module tb_integral_image_feeder;

    localparam int W = 20;
    localparam int B = 9;
    localparam int P = 8;
    localparam int N = W * W;

    logic           clk = 1'b0;
    logic           rst;
    logic [P-1:0]   pixel_in;
    logic           pixel_valid;
    logic           pixel_ready;
    logic           request_new_data;
    logic [N*B-1:0] image;
    logic           en;
    logic           saturated;

    integral_image_feeder #(.WIDTH(W), .BITSIZE(B), .PIXEL_BITS(P)) dut (
        .clk(clk),
        .rst(rst),
        .pixel_in(pixel_in),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .request_new_data(request_new_data),
        .image(image),
        .en(en),
        .saturated(saturated)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int idx;
        int val;
    } sb_t;

    sb_t exp_q[$];

    typedef struct {
        int val;
        bit gapped;
        int req_cycles;
        bit poke;
        int e0;
        int e1;
        int e19;
        int e20;
        int e399;
        bit sat;
    } vec_t;

    vec_t vecs[4];
    logic [N*B-1:0] ones_img;
    logic [N*B-1:0] prev_img;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] elem(input int idx);
        return 32'(image[idx*B +: B]);
    endfunction

    function automatic int model(input int val, input int idx);
        int x;
        int y;
        int s;
        x = idx % W;
        y = idx / W;
        s = val * (x + 1) * (y + 1);
        return (s > 511) ? 511 : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input int val, input bit gapped,
                              input int stop_at);
        int  cnt;
        int  cyc;
        bit  hs;
        bit  early;
        sb_t e;
        cnt = 0;
        cyc = 0;
        early = 1'b0;
        while (cnt < stop_at && cyc < 5000) begin
            pixel_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            pixel_in = P'(val);
            hs = pixel_valid && pixel_ready;
            if (hs) begin
                e.idx = cnt;
                e.val = model(val, cnt);
                exp_q.push_back(e);
            end
            tick();
            cyc++;
            if (hs) begin
                e = exp_q.pop_front();
                check($sformatf("elem%0d", e.idx), elem(e.idx), e.val);
                cnt++;
            end
            if (en && cnt < N) early = 1'b1;
        end
        pixel_valid = 1'b0;
        if (cyc >= 5000) check("timeout", cnt, stop_at);
        check("en_early", early, 0);
    endtask

    task automatic do_request(input int n);
        request_new_data = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) begin
                check("req_en_fall", en, 0);
                check("req_ready_rise", pixel_ready, 1);
            end
        end
        request_new_data = 1'b0;
        if (n > 1) check("one_transition", en, 0);
        check("sat_clear", saturated, 0);
    endtask

    task automatic check_full(input int val);
        int bad;
        bad = 0;
        for (int k = 0; k < N; k++)
            if (elem(k) !== 32'(model(val, k))) bad++;
        check("full_image_bad", bad, 0);
    endtask

    initial begin
        rst = 1'b1;
        pixel_valid = 1'b0;
        request_new_data = 1'b0;
        pixel_in = '0;

        vecs[0] = '{1,  0, 1, 0, 1,  2,  20,  2,  400, 0};
        vecs[1] = '{15, 0, 1, 0, 15, 30, 300, 30, 511, 1};
        vecs[2] = '{1,  1, 1, 0, 1,  2,  20,  2,  400, 0};
        vecs[3] = '{0,  0, 2, 1, 0,  0,  0,   0,  0,   0};

        repeat (3) tick();
        check("rst_ready", pixel_ready, 0);
        check("rst_en", en, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", pixel_ready, 1);
        check("post_rst_en", en, 0);
        check("post_rst_sat", saturated, 0);
        check("post_rst_img0", 32'(image == '0), 1);

        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                if (vecs[i].poke) begin
                    prev_img = image;
                    pixel_valid = 1'b1;
                    pixel_in = 8'hff;
                    repeat (3) tick();
                    check("poke_frozen", 32'(image === prev_img), 1);
                    check("poke_en", en, 1);
                    check("poke_ready", pixel_ready, 0);
                    pixel_valid = 1'b0;
                end
                do_request(vecs[i].req_cycles);
            end
            load_frame(vecs[i].val, vecs[i].gapped, N);
            check("done_en", en, 1);
            check("done_ready", pixel_ready, 0);
            check("done_sat", saturated, vecs[i].sat);
            check("idx0", elem(0), vecs[i].e0);
            check("idx1", elem(1), vecs[i].e1);
            check("idx19", elem(19), vecs[i].e19);
            check("idx20", elem(20), vecs[i].e20);
            check("idx399", elem(399), vecs[i].e399);
            check_full(vecs[i].val);
            if (i == 0) ones_img = image;
            else if (vecs[i].val == 1)
                check("ones_identical", 32'(image === ones_img), 1);
        end

        do_request(1);
        load_frame(1, 1'b0, 137);
        check("partial_en", en, 0);
        check("partial_elem136", elem(136), model(1, 136));
        rst = 1'b1;
        request_new_data = 1'b1;
        tick();
        check("mid_rst_ready", pixel_ready, 0);
        tick();
        rst = 1'b0;
        request_new_data = 1'b0;
        #1;
        check("mid_rst_img0", 32'(image == '0), 1);
        check("mid_rst_en", en, 0);
        check("mid_rst_sat", saturated, 0);
        check("mid_rst_ready1", pixel_ready, 1);
        load_frame(1, 1'b0, N);
        check("reload_en", en, 1);
        check("reload_identical", 32'(image === ones_img), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
